data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Clk  input  1  single clock; all state updates on posedge Clk.
REQ-002 Reset_N  input  1  asynchronous, active-low reset.
REQ-003 d_readM  input  1  CPU data read request, level, held while d_stall=1.
REQ-004 d_writeM  input  1  CPU data write request, level, held while d_stall=1.
REQ-005 d_address  input  16  CPU word address; tag=[15:5], index=[4:2], offset=[1:0].
REQ-006 d_data  inout  16  driven by cache only while d_readM=1 and hit; else high-Z; sampled as write data when d_writeM=1.
REQ-007 d_stall  output  1  CPU must freeze pipeline while 1.
REQ-008 m_readM, m_writeM  output  1 each  memory line read / line write strobes, level, held until m_ready.
REQ-009 m_address  output  16  memory line address, offset bits always 2'b00.
REQ-010 m_wdata  output  64  victim line, word 0 in [15:0].
REQ-011 m_rdata  input  64  fill line, word 0 in [15:0], valid in m_ready cycle.
REQ-012 m_ready  input  1  one-cycle completion pulse for current memory operation.
REQ-013 hit_count, miss_count  output  16 each  access statistics.

Function
REQ-014 Geometry: direct-mapped, 8 lines x 4 words x 16 bits; per-line valid, dirty, 11-bit tag; write-back, write-allocate.
REQ-015 Hit = valid[index] and tag match, evaluated combinationally in IDLE.
REQ-016 Read hit: d_data driven same cycle (zero latency), d_stall=0.
REQ-017 Write hit: word written and dirty set at next posedge, d_stall=0.
REQ-018 Request with miss in IDLE: d_stall=1 combinationally same cycle; state goes WRITEBACK if victim valid and dirty, else FILL.
REQ-019 WRITEBACK: m_writeM=1, m_address={victim tag,index,00}, m_wdata=victim line; on m_ready clear dirty, go FILL.
REQ-020 FILL: m_readM=1, m_address={req tag,index,00}; on m_ready install line, valid=1, dirty=0, go IDLE.
REQ-021 After return to IDLE the held request hits and completes per REQ-016/017; d_stall=1 in every WRITEBACK/FILL cycle.
REQ-022 m_readM and m_writeM never both 1; both 0 in IDLE.
REQ-023 d_readM and d_writeM both 1: write takes priority, no d_data drive.
REQ-024 Request dropped mid-miss: current memory op and fill still complete; line installed; no CPU response.
REQ-025 m_ready while IDLE: ignored.
REQ-026 miss_count +1 on each IDLE->WRITEBACK/FILL transition; hit_count +1 on each completed hit not immediately following a fill; both saturate at 16'hFFFF.

Reset
REQ-027 Reset_N=0 immediately: state IDLE, all valid/dirty=0, d_stall=0, m_readM=m_writeM=0, m_address=0, m_wdata=0, counters=0, d_data high-Z.
REQ-028 Reset mid-WRITEBACK/FILL aborts the operation; no line installed; data array contents need not be cleared.

Structure
REQ-029 Shared package holds line count, words per line, tag/index/offset widths and the state enum (IDLE, WRITEBACK, FILL).
REQ-030 One sub-module, cache_array: tag/valid/dirty/data storage with one read port and one line/word write port; FSM and counters stay in data_cache.

Verification
REQ-031 Cold read 0x0013, memory returns 64'h0004_0003_0002_0001 after 3 cycles -> d_stall 1 for 4 cycles, m_address=0x0010, then d_data=0x0004, miss_count=1, hit_count=0.
REQ-032 Then read 0x0011 -> d_data=0x0002, d_stall=0 same cycle, hit_count=1.
REQ-033 Write 0x0012<=0xBEEF (hit), then read 0x0032 (same index, other tag) -> WRITEBACK m_address=0x0010 m_wdata=64'h0004_BEEF_0002_0001, then FILL m_address=0x0030.
REQ-034 Assert Reset_N=0 during FILL -> m_readM drops at once, d_stall=0, re-read of same address misses again.
REQ-035 Drive 65536 hits -> hit_count holds 16'hFFFF.
REQ-036 d_readM=d_writeM=1 on hit -> write performed, d_data high-Z; m_readM&m_writeM never both 1 (assertion throughout).

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared geometry, FSM state encoding and small helpers for the direct-mapped
// write-back data cache (8 lines x 4 words x 16 bits).
package data_cache_pkg;

  localparam int LINES    = 8;
  localparam int WORDS    = 4;
  localparam int WORD_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int TAG_W    = 11;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int LINE_W   = WORDS * WORD_W;
  localparam int CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } state_e;

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Memory-side line bus between the cache (master) and backing memory (slave).
interface data_cache_if;
  import data_cache_pkg::*;

  // Handshake: the master raises exactly one of m_readM / m_writeM together with
  // m_address (and m_wdata for writes) and holds them all stable until the slave
  // returns a single-cycle m_ready pulse; read data on m_rdata is valid only in
  // that m_ready cycle. m_ready with no strobe raised is ignored.
  logic              m_readM;
  logic              m_writeM;
  logic [ADDR_W-1:0] m_address;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_ready;

  modport master (
    output m_readM, m_writeM, m_address, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_readM, m_writeM, m_address, m_wdata,
    output m_rdata, m_ready
  );

endinterface

// File: rtl/cache_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port that
// installs a whole line or updates a single word, plus a dirty-clear strobe.
module cache_array
  import data_cache_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset_N,
  input  logic [INDEX_W-1:0]  i_rd_index,
  output logic                o_rd_valid,
  output logic                o_rd_dirty,
  output logic [TAG_W-1:0]    o_rd_tag,
  output logic [LINE_W-1:0]   o_rd_line,
  input  logic                i_we,
  input  logic                i_we_line,
  input  logic [INDEX_W-1:0]  i_wr_index,
  input  logic [OFFSET_W-1:0] i_wr_offset,
  input  logic [TAG_W-1:0]    i_wr_tag,
  input  logic [LINE_W-1:0]   i_wr_line,
  input  logic [WORD_W-1:0]   i_wr_word,
  input  logic                i_clr_dirty,
  input  logic [INDEX_W-1:0]  i_clr_index
);

  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_dirty = r_dirty[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_line  = r_data[i_rd_index];

  // Only the state bits are reset; tag and data are don't-care while invalid.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      if (i_we && i_we_line) begin
        r_valid[i_wr_index] <= 1'b1;
        r_dirty[i_wr_index] <= 1'b0;
      end else if (i_we) begin
        r_dirty[i_wr_index] <= 1'b1;
      end
      if (i_clr_dirty) begin
        r_dirty[i_clr_index] <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (i_we && i_we_line) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_line;
    end else if (i_we) begin
      r_data[i_wr_index][{i_wr_offset, 4'b0000} +: WORD_W] <= i_wr_word;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache: zero-latency hits in IDLE,
// misses walk WRITEBACK (dirty victim) and FILL before the held request retries.
module data_cache
  import data_cache_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              d_readM,
  input  logic              d_writeM,
  input  logic [ADDR_W-1:0] d_address,
  inout  wire  [WORD_W-1:0] d_data,
  output logic              d_stall,
  data_cache_if.master      mem,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output state_e            o_state_dbg,
  output logic              o_d_oe
);

  state_e              r_state;
  state_e              w_next_state;
  logic [INDEX_W-1:0]  r_index;
  logic [TAG_W-1:0]    r_req_tag;
  logic                r_after_fill;
  logic [CNT_W-1:0]    r_hit_count;
  logic [CNT_W-1:0]    r_miss_count;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic [INDEX_W-1:0]  w_rd_index;
  logic                w_rd_valid;
  logic                w_rd_dirty;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [LINE_W-1:0]   w_rd_line;
  logic [WORD_W-1:0]   w_rd_word;
  logic                w_req;
  logic                w_hit;
  logic                w_we;
  logic                w_we_line;
  logic [INDEX_W-1:0]  w_wr_index;
  logic                w_clr_dirty;
  logic                w_drive;
  logic                w_stall;
  logic                w_hit_done;
  logic                w_miss_start;

  assign w_tag    = d_address[15:5];
  assign w_index  = d_address[4:2];
  assign w_offset = d_address[1:0];
  assign w_req    = d_readM | d_writeM;

  // Outside IDLE the request may have been dropped, so the array is addressed
  // by the index latched when the miss was taken.
  assign w_rd_index = (r_state == IDLE) ? w_index : r_index;
  assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
  assign w_rd_word  = w_rd_line[{w_offset, 4'b0000} +: WORD_W];

  cache_array u_array (
    .Clk         (Clk),
    .Reset_N     (Reset_N),
    .i_rd_index  (w_rd_index),
    .o_rd_valid  (w_rd_valid),
    .o_rd_dirty  (w_rd_dirty),
    .o_rd_tag    (w_rd_tag),
    .o_rd_line   (w_rd_line),
    .i_we        (w_we),
    .i_we_line   (w_we_line),
    .i_wr_index  (w_wr_index),
    .i_wr_offset (w_offset),
    .i_wr_tag    (r_req_tag),
    .i_wr_line   (mem.m_rdata),
    .i_wr_word   (d_data),
    .i_clr_dirty (w_clr_dirty),
    .i_clr_index (r_index)
  );

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_stall       = 1'b0;
    w_drive       = 1'b0;
    w_hit_done    = 1'b0;
    w_miss_start  = 1'b0;
    w_we          = 1'b0;
    w_we_line     = 1'b0;
    w_wr_index    = r_index;
    w_clr_dirty   = 1'b0;
    mem.m_readM   = 1'b0;
    mem.m_writeM  = 1'b0;
    mem.m_address = '0;
    mem.m_wdata   = '0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_hit) begin
            w_hit_done = 1'b1;
            if (d_writeM) begin
              w_we       = 1'b1;
              w_wr_index = w_index;
            end else begin
              w_drive = 1'b1;
            end
          end else begin
            w_stall      = 1'b1;
            w_miss_start = 1'b1;
            w_next_state = (w_rd_valid && w_rd_dirty) ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        w_stall       = 1'b1;
        mem.m_writeM  = 1'b1;
        mem.m_address = {w_rd_tag, r_index, 2'b00};
        mem.m_wdata   = w_rd_line;
        if (mem.m_ready) begin
          w_clr_dirty  = 1'b1;
          w_next_state = FILL;
        end
      end
      FILL: begin
        w_stall       = 1'b1;
        mem.m_readM   = 1'b1;
        mem.m_address = {r_req_tag, r_index, 2'b00};
        if (mem.m_ready) begin
          w_we         = 1'b1;
          w_we_line    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_index      <= '0;
      r_req_tag    <= '0;
      r_after_fill <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_miss_start) begin
        r_index      <= w_index;
        r_req_tag    <= w_tag;
        r_miss_count <= sat_inc(r_miss_count);
      end
      // The retry that completes right after a fill belongs to the miss.
      r_after_fill <= (r_state == FILL) && mem.m_ready;
      if (w_hit_done && !r_after_fill) begin
        r_hit_count <= sat_inc(r_hit_count);
      end
    end
  end

  // Reset forces the CPU side quiet immediately, even with a request still held.
  assign d_stall     = w_stall & Reset_N;
  assign o_d_oe      = w_drive & Reset_N;
  assign d_data      = o_d_oe ? w_rd_word : {WORD_W{1'bz}};
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_data_cache.sv
// Randomised scoreboard bench for data_cache against a transaction-level cache
// and memory model, plus directed cold-miss, writeback, reset and saturation cases.
module tb_data_cache;
  import data_cache_pkg::*;

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] line;
  } wb_t;

  logic        Clk = 1'b0;
  logic        Reset_N = 1'b0;
  logic        d_readM = 1'b0;
  logic        d_writeM = 1'b0;
  logic [15:0] d_address = '0;
  wire  [15:0] d_data;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wdata = '0;
  logic        d_stall;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  state_e      state_dbg;
  logic        d_oe;

  data_cache_if mem_bus ();

  assign d_data = tb_drv ? tb_wdata : 16'hzzzz;

  data_cache dut (
    .Clk         (Clk),
    .Reset_N     (Reset_N),
    .d_readM     (d_readM),
    .d_writeM    (d_writeM),
    .d_address   (d_address),
    .d_data      (d_data),
    .d_stall     (d_stall),
    .mem         (mem_bus.master),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .o_state_dbg (state_dbg),
    .o_d_oe      (d_oe)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];
  logic [15:0] fill_q[$];
  wb_t         wb_q[$];

  logic [15:0] last_read;
  logic [15:0] last_rd_addr;
  logic [15:0] last_wb_addr;
  logic [63:0] last_wb_line;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memories and reference model ----------------
  logic [15:0] mem_arr [65536];
  logic [15:0] ref_mem [65536];

  bit          mv [8];
  bit          md [8];
  logic [10:0] mt [8];
  logic [15:0] mdat [8][4];
  int          m_hits;
  int          m_misses;

  function automatic logic [63:0] model_line(input int idx);
    return {mdat[idx][3], mdat[idx][2], mdat[idx][1], mdat[idx][0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One CPU access at transaction level: allocate on miss (writing back a dirty
  // victim), then perform the access unless the CPU abandons it.
  task automatic model_access(input bit wr, input bit rd, input logic [15:0] addr,
                              input logic [15:0] wd, input bit respond, output bit hit);
    int          idx;
    int          off;
    logic [10:0] tag;
    logic [15:0] base;
    wb_t         e;
    idx = int'(addr[4:2]);
    off = int'(addr[1:0]);
    tag = addr[15:5];
    hit = mv[idx] && (mt[idx] == tag);
    if (!hit) begin
      if (m_misses < 65535) m_misses++;
      if (mv[idx] && md[idx]) begin
        base   = {mt[idx], addr[4:2], 2'b00};
        e.addr = base;
        e.line = model_line(idx);
        wb_q.push_back(e);
        for (int w = 0; w < 4; w++) ref_mem[base + 16'(w)] = mdat[idx][w];
      end
      base = {tag, addr[4:2], 2'b00};
      fill_q.push_back(base);
      for (int w = 0; w < 4; w++) mdat[idx][w] = ref_mem[base + 16'(w)];
      mv[idx] = 1'b1;
      md[idx] = 1'b0;
      mt[idx] = tag;
    end else if (m_hits < 65535) begin
      m_hits++;
    end
    if (respond) begin
      if (wr) begin
        mdat[idx][off] = wd;
        md[idx] = 1'b1;
      end else if (rd) begin
        exp_q.push_back(mdat[idx][off]);
      end
    end
  endtask

  // ---------------- memory slave ----------------
  int fixed_lat  = -1;
  bit hold_reads = 1'b0;

  initial begin
    int          lat;
    logic [15:0] base;
    lat = -1;
    mem_bus.m_ready = 1'b0;
    mem_bus.m_rdata = '0;
    forever begin
      @(posedge Clk);
      #1;
      mem_bus.m_ready = 1'b0;
      mem_bus.m_rdata = {$urandom, $urandom};
      if (!Reset_N) begin
        lat = -1;
      end else if (mem_bus.m_writeM || (mem_bus.m_readM && !hold_reads)) begin
        if (lat < 0) lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        if (lat == 0) begin
          base = mem_bus.m_address;
          if (mem_bus.m_writeM) begin
            for (int w = 0; w < 4; w++) mem_arr[base + 16'(w)] = mem_bus.m_wdata[16*w +: 16];
          end else begin
            mem_bus.m_rdata = {mem_arr[base + 16'd3], mem_arr[base + 16'd2],
                               mem_arr[base + 16'd1], mem_arr[base]};
          end
          mem_bus.m_ready = 1'b1;
          lat = -1;
        end else begin
          lat--;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    wb_t e;
    if (Reset_N) begin
      check("m_strobe_mutex", 64'(mem_bus.m_readM & mem_bus.m_writeM), 64'd0);
      check("d_data_drive", 64'(d_oe), 64'(d_readM && !d_writeM && !d_stall));
      if (state_dbg == IDLE)
        check("idle_strobes", 64'({mem_bus.m_readM, mem_bus.m_writeM}), 64'd0);
      if (mem_bus.m_readM) last_rd_addr = mem_bus.m_address;
      if (d_readM && !d_writeM && !d_stall) begin
        last_read = d_data;
        if (exp_q.size() == 0) check("unexpected_read", 64'(d_data), 64'hDEAD_0000);
        else check("read_data", 64'(d_data), 64'(exp_q.pop_front()));
      end
      if (mem_bus.m_ready && mem_bus.m_writeM) begin
        last_wb_addr = mem_bus.m_address;
        last_wb_line = mem_bus.m_wdata;
        if (wb_q.size() == 0) begin
          check("unexpected_writeback", 64'(mem_bus.m_address), 64'hDEAD_0001);
        end else begin
          e = wb_q.pop_front();
          check("wb_address", 64'(mem_bus.m_address), 64'(e.addr));
          check("wb_data", mem_bus.m_wdata, e.line);
        end
      end
      if (mem_bus.m_ready && mem_bus.m_readM) begin
        if (fill_q.size() == 0) check("unexpected_fill", 64'(mem_bus.m_address), 64'hDEAD_0002);
        else check("fill_address", 64'(mem_bus.m_address), 64'(fill_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_access(input bit wr, input bit rd, input logic [15:0] addr,
                              input logic [15:0] wd, output int stall_cycles);
    bit h;
    model_access(wr, rd, addr, wd, 1'b1, h);
    d_address = addr;
    d_writeM  = wr;
    d_readM   = rd;
    tb_drv    = wr;
    tb_wdata  = wd;
    stall_cycles = 0;
    forever begin
      @(negedge Clk);
      if (!d_stall) break;
      stall_cycles++;
      if (stall_cycles > 200) begin
        check("access_timeout", 64'(stall_cycles), 64'd0);
        break;
      end
    end
    @(posedge Clk);
    #1;
    d_readM  = 1'b0;
    d_writeM = 1'b0;
    tb_drv   = 1'b0;
  endtask

  task automatic hold_reads_hit(input logic [15:0] addr, input int n);
    d_address = addr;
    d_readM   = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mdat[int'(addr[4:2])][int'(addr[1:0])]);
      if (m_hits < 65535) m_hits++;
      @(posedge Clk);
      #1;
    end
    d_readM = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    forever begin
      @(negedge Clk);
      if (state_dbg == IDLE) break;
      cyc++;
      if (cyc > 100) begin
        check(name, 64'(state_dbg), 64'(IDLE));
        break;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_d_stall"}, 64'(d_stall), 64'd0);
    check({tag, "_m_readM"}, 64'(mem_bus.m_readM), 64'd0);
    check({tag, "_m_writeM"}, 64'(mem_bus.m_writeM), 64'd0);
    check({tag, "_m_address"}, 64'(mem_bus.m_address), 64'd0);
    check({tag, "_m_wdata"}, mem_bus.m_wdata, 64'd0);
    check({tag, "_hit_count"}, 64'(hit_count), 64'd0);
    check({tag, "_miss_count"}, 64'(miss_count), 64'd0);
    check({tag, "_d_oe"}, 64'(d_oe), 64'd0);
    check({tag, "_state"}, 64'(state_dbg), 64'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5_000_000;
    n_fail++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int          st;
    int          cyc;
    int          r;
    bit          h;
    logic [15:0] a;
    logic [15:0] v;

    for (int i = 0; i < 65536; i++) begin
      v = 16'($urandom);
      mem_arr[i] = v;
      ref_mem[i] = v;
    end
    for (int i = 0; i < 4; i++) begin
      mem_arr[16 + i] = 16'(i + 1);
      ref_mem[16 + i] = 16'(i + 1);
    end
    model_reset();

    // Reset state
    repeat (3) @(posedge Clk);
    #1;
    check_reset_outputs("reset");
    @(negedge Clk);
    Reset_N = 1'b1;
    @(posedge Clk);
    #1;

    // Cold read miss with 3-cycle memory latency
    fixed_lat = 2;
    drive_access(1'b0, 1'b1, 16'h0013, 16'h0000, st);
    fixed_lat = -1;
    check("cold_stall_cycles", 64'(st), 64'd4);
    check("cold_fill_address", 64'(last_rd_addr), 64'h0010);
    check("cold_read_data", 64'(last_read), 64'h0004);
    check("cold_miss_count", 64'(miss_count), 64'd1);
    check("cold_hit_count", 64'(hit_count), 64'd0);

    // Read hit in the same line
    drive_access(1'b0, 1'b1, 16'h0011, 16'h0000, st);
    check("hit_stall_cycles", 64'(st), 64'd0);
    check("hit_read_data", 64'(last_read), 64'h0002);
    check("hit_count_1", 64'(hit_count), 64'd1);

    // Write hit, then conflicting read that is reset during its fill
    drive_access(1'b1, 1'b0, 16'h0012, 16'hBEEF, st);
    check("write_hit_stall", 64'(st), 64'd0);
    check("hit_count_2", 64'(hit_count), 64'd2);
    hold_reads = 1'b1;
    model_access(1'b0, 1'b1, 16'h0032, 16'h0000, 1'b0, h);
    d_address = 16'h0032;
    d_readM   = 1'b1;
    cyc = 0;
    forever begin
      @(negedge Clk);
      if (mem_bus.m_readM) break;
      cyc++;
      if (cyc > 50) begin
        check("fill_start_timeout", 64'(cyc), 64'd0);
        break;
      end
    end
    check("conflict_wb_address", 64'(last_wb_addr), 64'h0010);
    check("conflict_wb_data", last_wb_line, 64'h0004_BEEF_0002_0001);
    check("conflict_fill_address", 64'(mem_bus.m_address), 64'h0030);
    #2;
    Reset_N = 1'b0;
    #1;
    check_reset_outputs("midfill_reset");
    model_reset();
    fill_q.delete();
    d_readM = 1'b0;
    @(negedge Clk);
    Reset_N    = 1'b1;
    hold_reads = 1'b0;
    @(posedge Clk);
    #1;
    drive_access(1'b0, 1'b1, 16'h0032, 16'h0000, st);
    check("reread_misses", 64'(st > 0), 64'd1);
    check("reread_miss_count", 64'(miss_count), 64'd1);

    // Read and write together on a hit: write wins, no drive
    drive_access(1'b1, 1'b1, 16'h0032, 16'h1234, st);
    drive_access(1'b0, 1'b1, 16'h0032, 16'h0000, st);
    check("rw_priority_data", 64'(last_read), 64'h1234);

    // Request dropped mid-miss still installs the line
    model_access(1'b0, 1'b1, 16'h0AA8, 16'h0000, 1'b0, h);
    d_address = 16'h0AA8;
    d_readM   = 1'b1;
    @(posedge Clk);
    #1;
    d_readM = 1'b0;
    wait_idle("drop_idle_timeout");
    drive_access(1'b0, 1'b1, 16'h0AA8, 16'h0000, st);
    check("drop_then_hit", 64'(st), 64'd0);

    // Randomised traffic over a conflict-heavy address range
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      a = {11'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      v = 16'($urandom);
      if (r < 5)      drive_access(1'b0, 1'b1, a, v, st);
      else if (r < 9) drive_access(1'b1, 1'b0, a, v, st);
      else            drive_access(1'b1, 1'b1, a, v, st);
    end
    check("random_hit_count", 64'(hit_count), 64'(m_hits));
    check("random_miss_count", 64'(miss_count), 64'(m_misses));

    // Hit counter saturation
    drive_access(1'b0, 1'b1, 16'h0044, 16'h0000, st);
    hold_reads_hit(16'h0044, 65540);
    check("sat_hit_count", 64'(hit_count), 64'hFFFF);
    check("sat_miss_count", 64'(miss_count), 64'(m_misses));

    repeat (5) @(posedge Clk);
    #1;
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("fill_q_drained", 64'(fill_q.size()), 64'd0);
    check("wb_q_drained", 64'(wb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
